// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped cache.
// The DM_CACHE_STATS_EN build also uses the saturating counter helper below.
package cache_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_IDX_W  = 3;
  localparam int CNT_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_WTHRU,
    ST_RESP
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Line storage: per-line valid bits in flops, tag and data in RAM-style arrays.
// One shared read/write index; read data is registered, so it appears the cycle after the index.
module dm_cache_array #(
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_all,
  input  logic [IDX_W-1:0]  addr,
  input  logic              we,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic              rvalid_q;
  logic [TAG_W-1:0]  rtag_q;
  logic [DATA_W-1:0] rdata_q;

  // Valid bits are the only reset storage; a clear wipes every line at once.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
        end else if (clear_all) begin
          valid_q[gi] <= 1'b0;
        end else if (we && (addr == IDX_W'(gi))) begin
          valid_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= valid_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[addr]  <= wtag;
      data_mem[addr] <= wdata;
    end
    rtag_q  <= tag_mem[addr];
    rdata_q <= data_mem[addr];
  end

  assign rvalid = rvalid_q;
  assign rtag   = rtag_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one word per line.
// Define DM_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dm_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - IDX_W;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              hit_q;
  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              mem_req_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              arr_clear;
  logic [IDX_W-1:0]  arr_addr;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [DATA_W-1:0] arr_data;
  logic              lookup_hit;

  // In IDLE the array is indexed by the live request so the registered read
  // is ready exactly when LOOKUP begins; afterwards the captured address drives it.
  assign arr_addr   = (state_q == ST_IDLE) ? req_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];
  assign arr_clear  = (state_q == ST_IDLE) && flush;
  assign lookup_hit = arr_valid && (arr_tag == addr_q[ADDR_W-1:IDX_W]);
  assign arr_we     = ((state_q == ST_LOOKUP) && wr_q && lookup_hit) ||
                      ((state_q == ST_REFILL) && mem_ack);
  assign arr_wdata  = (state_q == ST_REFILL) ? mem_rdata : wdata_q;

  dm_cache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clear_all(arr_clear),
    .addr     (arr_addr),
    .we       (arr_we),
    .wtag     (addr_q[ADDR_W-1:IDX_W]),
    .wdata    (arr_wdata),
    .rvalid   (arr_valid),
    .rtag     (arr_tag),
    .rdata    (arr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      hit_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // flush wins over a simultaneous request
          if (!flush && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hit_q <= lookup_hit;
          if (wr_q) begin
            mem_req_q   <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= ST_WTHRU;
          end else if (lookup_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= 1'b1;
            rsp_data_q  <= arr_data;
            state_q     <= ST_RESP;
          end else begin
            mem_req_q  <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= addr_q;
            state_q    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= mem_rdata;
            state_q     <= ST_RESP;
          end
        end
        ST_WTHRU: begin
          if (mem_ack) begin
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= hit_q;
            rsp_data_q  <= wdata_q;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_data  = rsp_data_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DM_CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == ST_RESP) begin
      if (rsp_hit_q) begin
        hit_cnt_q <= sat_inc(hit_cnt_q);
      end else begin
        miss_cnt_q <= sat_inc(miss_cnt_q);
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 Parameter ADDR_W, default 8, byte-free word address width.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter IDX_W, default 3, index width; LINES = 2**IDX_W; TAG_W = ADDR_W-IDX_W (IDX_W < ADDR_W).
REQ-004 Ports: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  CPU request present.
REQ-008 req_wr  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  word address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_ready  out  1  high only in IDLE with flush low.
REQ-012 rsp_valid  out  1  one-cycle response pulse.
REQ-013 rsp_data  out  DATA_W  read data (writes: req_wdata echoed).
REQ-014 rsp_hit  out  1  lookup hit, valid with rsp_valid.
REQ-015 flush  in  1  invalidate all lines.
REQ-016 mem_req, mem_wr  out  1 each  backing-memory request/direction, held until mem_ack.
REQ-017 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W; mem_ack  in  1.

Function
REQ-018 Direct-mapped, one word per line; index = req_addr[IDX_W-1:0], tag = upper TAG_W bits; per line: valid bit, tag, data.
REQ-019 States IDLE, LOOKUP, REFILL, WTHRU, RESP; request accepted on edge with req_valid && req_ready; address/data/wr captured.
REQ-020 IDLE->LOOKUP on accept; LOOKUP: hit = valid[idx] && tag match.
REQ-021 Read hit: LOOKUP->RESP; rsp_valid high in cycle 2 after accept edge, rsp_hit=1, rsp_data=line data.
REQ-022 Read miss: LOOKUP->REFILL; mem_req=1, mem_wr=0, mem_addr=captured addr until mem_ack; on mem_ack line written (valid=1, tag, mem_rdata), ->RESP with rsp_data=mem_rdata, rsp_hit=0.
REQ-023 Write (write-through, no-write-allocate): LOOKUP->WTHRU; on hit line data updated in LOOKUP; mem_req=1, mem_wr=1, mem_wdata=captured data until mem_ack; ->RESP, rsp_hit=lookup result; miss leaves array unchanged.
REQ-024 RESP->IDLE unconditionally; rsp_valid exactly one cycle per accepted request.
REQ-025 mem_ack outside REFILL/WTHRU ignored; mem_ack same cycle as mem_req rise accepted (zero-wait memory).
REQ-026 flush sampled only in IDLE, priority over req_valid: all valid bits cleared on that edge, no request accepted; flush in other states ignored.
REQ-027 Index wrap: addresses differing only in tag evict each other (refill overwrites tag).

Reset
REQ-028 rst: state=IDLE, all valid bits 0, rsp_valid=0, rsp_hit=0, rsp_data=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0; data/tag arrays not reset.
REQ-029 rst mid-REFILL/WTHRU abandons transaction; no rsp_valid; mem_req drops asynchronously.

Configuration
REQ-030 Macro DM_CACHE_STATS_EN: when defined, outputs hit_cnt and miss_cnt (32 bits each) count RESP cycles by rsp_hit, saturating at all-ones, cleared by rst only (not flush); when undefined, ports and counters absent, behaviour otherwise identical.

Structure
REQ-031 Package cache_pkg holds state enum type and default parameter constants.
REQ-032 Sub-module dm_cache_array: valid/tag/data storage with single read/write port and clear-all-valid input.

Verification
REQ-033 Reset, read 0x15 -> miss; mem_req with mem_addr=0x15; ack rdata=0xA5 -> rsp_data=0xA5, rsp_hit=0.
REQ-034 Read 0x15 again -> rsp_valid 2 cycles after accept, rsp_hit=1, rsp_data=0xA5, no mem_req.
REQ-035 Write 0x15 data 0x3C -> mem_wr cycle, rsp_hit=1; read 0x15 -> 0x3C hit. Write 0x0D miss -> later read 0x0D misses.
REQ-036 Read 0x1D (same index 5) -> miss, evicts; read 0x15 -> miss.
REQ-037 flush in IDLE with req_valid high -> req not accepted; next read 0x1D misses.
REQ-038 rst asserted during REFILL with mem_ack delayed 5 cycles -> mem_req low immediately, no rsp_valid, next read misses.
